dds_rom_scheduler: RTL and testbench

- Two-channel DDS sequencer that time-multiplexes one sine lookup ROM between two channels.
- The ROM is 1024 entries, 16-bit signed, with a registered read (1-cycle latency).
- Each channel owns a phase accumulator. On every sample strobe the block advances both phases, issues both ROM reads back-to-back, and captures both results.
- Sits between the sample-rate timing generator and the output/mixer stage.

---
 rtl/dds_rom_scheduler.sv | 109 ++++++++++
 tb/tb_dds_rom_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_rom_scheduler.sv
// Two-channel DDS sequencer sharing one registered-read sine ROM.
// Each sample tick walks IDLE -> ADDR1 -> CAP0 -> CAP1 to issue both reads and capture both results.
module dds_rom_scheduler #(
    parameter int PHASE_W  = 32,
    parameter int LUT_BITS = 10,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      phase_clear,
    input  logic                      sample_tick,
    input  logic        [PHASE_W-1:0] tune_word0,
    input  logic        [PHASE_W-1:0] tune_word1,
    output logic        [ADDR_W-1:0]  rom_addr,
    input  logic signed [DATA_W-1:0]  rom_data,
    output logic signed [DATA_W-1:0]  sample0,
    output logic signed [DATA_W-1:0]  sample1,
    output logic                      sample_valid,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR1 = 2'd1,
        CAP0  = 2'd2,
        CAP1  = 2'd3
    } state_t;

    state_t                     state_q;
    logic        [PHASE_W-1:0]  phase0_q;
    logic        [PHASE_W-1:0]  phase1_q;
    logic        [PHASE_W-1:0]  phase0_d;
    logic        [PHASE_W-1:0]  phase1_d;
    logic        [ADDR_W-1:0]   rom_addr_q;
    logic signed [DATA_W-1:0]   sample0_q;
    logic signed [DATA_W-1:0]   sample1_q;
    logic                       valid_q;
    logic                       overrun_q;
    logic                       tick_req;

    // Table index is the top LUT_BITS of the pre-increment phase, zero-extended to the port width.
    function automatic logic [ADDR_W-1:0] lut_index(input logic [PHASE_W-1:0] ph);
        return ADDR_W'(ph[PHASE_W-1 -: LUT_BITS]);
    endfunction

    assign phase0_d = phase0_q + tune_word0;
    assign phase1_d = phase1_q + tune_word1;
    assign tick_req = sample_tick & enable & ~phase_clear;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase0_q   <= '0;
            phase1_q   <= '0;
            rom_addr_q <= '0;
            sample0_q  <= '0;
            sample1_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (phase_clear) begin
                // Abort: phases restart at zero, samples and ROM address keep their last values.
                state_q  <= IDLE;
                phase0_q <= '0;
                phase1_q <= '0;
            end else begin
                if (tick_req && state_q != IDLE) begin
                    overrun_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (tick_req) begin
                            rom_addr_q <= lut_index(phase0_q);
                            phase0_q   <= phase0_d;
                            state_q    <= ADDR1;
                        end
                    end
                    ADDR1: begin
                        rom_addr_q <= lut_index(phase1_q);
                        phase1_q   <= phase1_d;
                        state_q    <= CAP0;
                    end
                    CAP0: begin
                        sample0_q <= rom_data;
                        state_q   <= CAP1;
                    end
                    CAP1: begin
                        sample1_q <= rom_data;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample0      = sample0_q;
    assign sample1      = sample1_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dds_rom_scheduler.sv
// Scoreboard bench for dds_rom_scheduler: a phase/countdown reference model predicts ROM addresses,
// sample pairs and their due cycle; a negedge monitor compares whatever the DUT presents.
module tb_dds_rom_scheduler;
  localparam int PHASE_W  = 32;
  localparam int LUT_BITS = 10;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic phase_clear = 1'b0;
  logic sample_tick = 1'b0;
  logic [PHASE_W-1:0] tune_word0 = '0;
  logic [PHASE_W-1:0] tune_word1 = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic signed [DATA_W-1:0] rom_data = '0;
  logic signed [DATA_W-1:0] sample0;
  logic signed [DATA_W-1:0] sample1;
  logic sample_valid;
  logic busy;
  logic overrun;

  dds_rom_scheduler #(
    .PHASE_W(PHASE_W), .LUT_BITS(LUT_BITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .phase_clear(phase_clear),
    .sample_tick(sample_tick), .tune_word0(tune_word0), .tune_word1(tune_word1),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample0(sample0), .sample1(sample1),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Sine ROM stand-in: random contents make any wrong index visible; registered read.
  logic signed [DATA_W-1:0] rom_mem [1024];
  always @(posedge clock) rom_data <= rom_mem[rom_addr[LUT_BITS-1:0]];

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: phases as plain modulo-2^32 numbers, a countdown of busy cycles,
  // and a queue of predicted (sample0, sample1, due cycle) results.
  typedef struct {
    logic signed [DATA_W-1:0] s0;
    logic signed [DATA_W-1:0] s1;
    int due;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  logic [PHASE_W-1:0] m_ph0 = '0;
  logic [PHASE_W-1:0] m_ph1 = '0;
  int m_busy = 0;
  bit m_ovr = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  int m_idx0 = 0;
  int n_valid = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph0 = '0;
      m_ph1 = '0;
      m_busy = 0;
      m_ovr = 1'b0;
      m_addr = '0;
      exp_q.delete();
    end else begin
      int idx1;
      bit was_busy;
      exp_t e;
      cyc++;
      if (phase_clear) begin
        m_ph0 = '0;
        m_ph1 = '0;
        m_busy = 0;
        exp_q.delete();
      end else begin
        was_busy = (m_busy > 0);
        if (m_busy == 3) begin
          idx1 = int'(m_ph1 / 32'h0040_0000);
          m_ph1 = m_ph1 + tune_word1;
          m_addr = ADDR_W'(idx1);
          e.s0 = rom_mem[m_idx0];
          e.s1 = rom_mem[idx1];
          e.due = cyc + 2;
          exp_q.push_back(e);
        end
        if (m_busy > 0) m_busy--;
        if (sample_tick && enable) begin
          if (was_busy) m_ovr = 1'b1;
          else begin
            m_idx0 = int'(m_ph0 / 32'h0040_0000);
            m_ph0 = m_ph0 + tune_word0;
            m_addr = ADDR_W'(m_idx0);
            m_busy = 3;
          end
        end
      end
    end
  end

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      bit due_now;
      exp_t e;
      chk("busy", 32'(busy), 32'(m_busy > 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("sample_valid", 32'(sample_valid), 32'(due_now));
      if (sample_valid) n_valid++;
      if (due_now) begin
        e = exp_q.pop_front();
        if (sample_valid) begin
          chk("sample0", 32'(sample0), 32'(e.s0));
          chk("sample1", 32'(sample1), 32'(e.s1));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_sample0"}, 32'(sample0), 32'd0);
    chk({tag, "_sample1"}, 32'(sample1), 32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = DATA_W'($urandom);
    rom_mem[0] = 16'sh1234;
    step(2);
    chk_zero_outputs("reset");
    reset = 1'b0;
    step(1);

    // Nominal rates: ch0 steps one entry, ch1 a quarter table per tick.
    enable = 1'b1;
    tune_word0 = 32'h0040_0000;
    tune_word1 = 32'h4000_0000;
    n0 = n_valid;
    repeat (5) begin
      tick();
      step(7);
    end
    chk("nominal_count", 32'(n_valid - n0), 32'd5);

    // Channel 0 runs backwards through the table via wrap-around.
    phase_clear = 1'b1;
    step(1);
    phase_clear = 1'b0;
    tune_word0 = 32'hFFC0_0000;
    repeat (4) begin
      tick();
      step(5);
    end

    // Tick while busy is dropped and latches overrun; tick in the valid cycle is accepted.
    phase_clear = 1'b1;
    step(1);
    phase_clear = 1'b0;
    tune_word0 = 32'h0040_0000;
    n0 = n_valid;
    tick();
    step(1);
    tick();
    step(1);
    tick();
    step(6);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("overrun_count", 32'(n_valid - n0), 32'd2);

    // Back-to-back at minimum spacing.
    do_reset();
    tune_word0 = $urandom;
    tune_word1 = $urandom;
    n0 = n_valid;
    repeat (16) begin
      tick();
      step(3);
    end
    step(4);
    chk("b2b_count", 32'(n_valid - n0), 32'd16);
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // Ticks with enable low are ignored entirely.
    enable = 1'b0;
    n0 = n_valid;
    repeat (3) begin
      tick();
      step(5);
    end
    chk("disabled_count", 32'(n_valid - n0), 32'd0);
    enable = 1'b1;

    // phase_clear while in CAP0 aborts; next tick reads index 0 on both channels.
    tick();
    step(1);
    phase_clear = 1'b1;
    step(1);
    phase_clear = 1'b0;
    step(4);
    tick();
    chk("clr_idx0", 32'(rom_addr), 32'd0);
    step(1);
    chk("clr_idx1", 32'(rom_addr), 32'd0);
    step(5);

    // Asynchronous reset mid-CAP0.
    tick();
    step(1);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(2);

    // Randomised traffic including overruns, enable drops and clears.
    repeat (400) begin
      sample_tick = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 9) != 0);
      phase_clear = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 20) == 0) tune_word0 = $urandom;
      if ($urandom_range(0, 20) == 0) tune_word1 = $urandom;
      step(1);
    end
    sample_tick = 1'b0;
    phase_clear = 1'b0;
    step(6);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
